// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the bytewise reflected CRC-32 step used on the receive path.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam int          ETH_FCS_BYTES   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_TAIL
  } rx_state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_bytes.sv
// Combinational CRC-32 update over the first i_cnt bytes of a B-byte beat.
module eth_crc32_bytes
  import eth_pkg::*;
#(
  parameter int B = 4
) (
  input  logic [31:0]         i_crc,
  input  logic [8*B-1:0]      i_data,
  input  logic [$clog2(B):0]  i_cnt,
  output logic [31:0]         o_crc
);

  logic [B:0][31:0] chain;

  assign chain[0] = i_crc;

  // chain[k] is the CRC after bytes 0..k-1; the count picks the tap
  for (genvar g = 0; g < B; g++) begin : g_step
    assign chain[g+1] = crc32_byte(chain[g], i_data[8*g +: 8]);
  end

  assign o_crc = chain[i_cnt];

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Rx FCS checker: one beat of hold-back so the trailing FCS can be stripped,
// CRC/length checked, and the verdict attached to the final payload beat.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int DATAPATH_WIDTH  = 32,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [DATAPATH_WIDTH-1:0]            i_eths_slave_data,
  input  logic [$clog2(DATAPATH_WIDTH/8)-1:0]  i_eths_slave_keep,
  input  logic                                 i_eths_slave_valid,
  input  logic                                 i_eths_slave_abort,
  input  logic                                 i_eths_slave_last,
  output logic [DATAPATH_WIDTH-1:0]            o_eths_master_data,
  output logic [$clog2(DATAPATH_WIDTH/8)-1:0]  o_eths_master_keep,
  output logic                                 o_eths_master_valid,
  output logic                                 o_eths_master_abort,
  output logic                                 o_eths_master_last,
  output logic                                 o_fcs_err,
  output logic                                 o_len_err
);

  localparam int          B     = DATAPATH_WIDTH / 8;
  localparam int          KW    = $clog2(B);
  localparam logic [KW:0] FCS_N = (KW+1)'(ETH_FCS_BYTES);
  localparam logic [KW:0] ONE   = (KW+1)'(1);

  typedef struct packed {
    logic [DATAPATH_WIDTH-1:0] data;
    logic [KW-1:0]             keep;
    logic                      valid;
    logic                      last;
    logic                      abort;
    logic                      fcs_err;
    logic                      len_err;
  } beat_t;

  rx_state_e                 state_q, state_d;
  beat_t                     out_q, out_d, tail_q, tail_d;
  beat_t                     abort_b, runt_b, hold_b, hlast_b, trim_b;
  logic [DATAPATH_WIDTH-1:0] hold_q, hold_d;
  logic [31:0]               crc_q, crc_d, crc_next;
  logic [15:0]               len_q, len_d, len_next;
  logic [16:0]               len_sum;
  logic [KW:0]               n, cnt, trim_n, hold_n;
  logic                      big, fcs_bad, len_bad;

  function automatic logic [DATAPATH_WIDTH-1:0] mask_bytes(input logic [DATAPATH_WIDTH-1:0] d,
                                                           input logic [KW:0] c);
    logic [DATAPATH_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < B; i++) if ((KW+1)'(i) < c) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  assign n       = {1'b0, i_eths_slave_keep} + ONE;
  assign cnt     = i_eths_slave_last ? n : (KW+1)'(B);
  assign len_sum = {1'b0, len_q} + 17'(cnt);
  assign len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign big     = n > FCS_N;
  assign trim_n  = n - FCS_N;
  // FCS straddles the held beat: B-(4-n) of its bytes are payload
  assign hold_n  = (KW+1)'(B - ETH_FCS_BYTES) + n;
  assign fcs_bad = crc_next != CRC32_RESIDUE;
  assign len_bad = (MIN_FRAME_BYTES != 0 && 32'(len_next) < MIN_FRAME_BYTES) ||
                   (MAX_FRAME_BYTES != 0 && 32'(len_next) > MAX_FRAME_BYTES);

  eth_crc32_bytes #(.B(B)) u_crc (
    .i_crc  (crc_q),
    .i_data (i_eths_slave_data),
    .i_cnt  (cnt),
    .o_crc  (crc_next)
  );

  always_comb begin
    abort_b       = '0;
    abort_b.valid = 1'b1;
    abort_b.last  = 1'b1;
    abort_b.abort = 1'b1;
    runt_b         = abort_b;
    runt_b.fcs_err = fcs_bad;
    runt_b.len_err = len_bad;
    hold_b       = '0;
    hold_b.data  = hold_q;
    hold_b.keep  = '1;
    hold_b.valid = 1'b1;
    hlast_b         = hold_b;
    hlast_b.data    = mask_bytes(hold_q, hold_n);
    hlast_b.keep    = KW'(hold_n - ONE);
    hlast_b.last    = 1'b1;
    hlast_b.abort   = fcs_bad | len_bad;
    hlast_b.fcs_err = fcs_bad;
    hlast_b.len_err = len_bad;
    trim_b      = hlast_b;
    trim_b.data = mask_bytes(i_eths_slave_data, trim_n);
    trim_b.keep = KW'(trim_n - ONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_eths_slave_valid) begin
      if (i_eths_slave_abort)     state_d = (state_q == ST_TAIL) ? ST_TAIL : ST_IDLE;
      else if (!i_eths_slave_last) state_d = ST_HOLD;
      else if (big)               state_d = ST_TAIL;
      else                        state_d = (state_q == ST_TAIL) ? ST_TAIL : ST_IDLE;
    end else if (state_q == ST_TAIL) begin
      state_d = ST_IDLE;
    end
  end

  // A pending tail always owns the output slot; anything else that must be
  // emitted in that cycle is parked in the tail register instead.
  always_comb begin
    out_d  = '0;
    tail_d = tail_q;
    hold_d = hold_q;
    crc_d  = crc_q;
    len_d  = len_q;
    if (state_q == ST_TAIL) out_d = tail_q;
    if (i_eths_slave_valid) begin
      if (i_eths_slave_abort) begin
        crc_d = CRC32_INIT;
        len_d = '0;
        if (state_q == ST_TAIL) tail_d = abort_b;
        else                    out_d  = abort_b;
      end else if (!i_eths_slave_last) begin
        crc_d  = crc_next;
        len_d  = len_next;
        hold_d = i_eths_slave_data;
        if (state_q == ST_HOLD) out_d = hold_b;
      end else begin
        crc_d = CRC32_INIT;
        len_d = '0;
        if (big) begin
          tail_d = trim_b;
          if (state_q == ST_HOLD) out_d = hold_b;
        end else if (state_q == ST_HOLD) begin
          out_d = hlast_b;
        end else if (state_q == ST_TAIL) begin
          tail_d = runt_b;
        end else begin
          out_d = runt_b;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q  <= '0;
      tail_q <= '0;
      hold_q <= '0;
      crc_q  <= CRC32_INIT;
      len_q  <= '0;
    end else begin
      out_q  <= out_d;
      tail_q <= tail_d;
      hold_q <= hold_d;
      crc_q  <= crc_d;
      len_q  <= len_d;
    end
  end

  assign o_eths_master_data  = out_q.data;
  assign o_eths_master_keep  = out_q.keep;
  assign o_eths_master_valid = out_q.valid;
  assign o_eths_master_abort = out_q.abort;
  assign o_eths_master_last  = out_q.last;
  assign o_fcs_err           = out_q.fcs_err;
  assign o_len_err           = out_q.len_err;

endmodule

// File: doc/eth_rx_fcs_check.md
Name: eth_rx_fcs_check

Overview:
- Receive-path Ethernet stream stage between the MAC/PCS byte aligner and the frame parser.
- Computes CRC-32 over every frame, strips the trailing 4-byte FCS and flags bad frames with abort on the final output beat.
- Enforces min/max frame length.
- Generalised over datapath width; valid/abort/last stream, no backpressure.

Parameters:
DATAPATH_WIDTH, 32, stream width in bits; legal 32, 64, 128 (B = DATAPATH_WIDTH/8 bytes per beat, B >= 4)
MIN_FRAME_BYTES, 64, minimum frame length incl. FCS; 0 disables the check
MAX_FRAME_BYTES, 1522, maximum frame length incl. FCS; 0 disables the check

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_eths_slave_data  in  DATAPATH_WIDTH  frame bytes, byte 0 in [7:0]
i_eths_slave_keep  in  $clog2(B)  valid bytes minus 1; meaningful only with last, otherwise all B bytes valid
i_eths_slave_valid  in  1  beat valid
i_eths_slave_abort  in  1  upstream error; ends the frame
i_eths_slave_last  in  1  final beat of frame (includes FCS)
o_eths_master_data  out  DATAPATH_WIDTH  payload bytes, FCS removed
o_eths_master_keep  out  $clog2(B)  same encoding as input
o_eths_master_valid  out  1  beat valid
o_eths_master_abort  out  1  frame bad; asserted only with last
o_eths_master_last  out  1  final payload beat
o_fcs_err  out  1  one-cycle pulse: frame ended with CRC mismatch
o_len_err  out  1  one-cycle pulse: frame ended with length violation

Behaviour:
- Reset: all outputs 0 (data, keep, valid, abort, last, o_fcs_err, o_len_err). Hold and tail registers empty. CRC = 0xFFFFFFFF. Length counter = 0.
- CRC: reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF, LSB first), updated over all valid input bytes, FCS included.
- Good frame: the register value after the last byte, before final XOR, equals residue 0xDEBB20E3.
- Length counter: 16 bits, saturating; counts input bytes including FCS.
- Hold-back:
  - Each non-last input beat is stored in the hold register.
  - The previously held beat is emitted registered, with valid=1, last=0, keep=B-1, in the cycle after the new beat arrives.
  - Payload latency is one input beat plus one cycle.
- Last input beat with n valid bytes (n = keep+1):
  - n > 4: the held beat (if present) is emitted non-last in the next cycle. The last beat is trimmed to n-4 bytes and emitted from the tail register one cycle later, with last=1 and keep=n-5.
  - n <= 4 and hold present: the held beat is emitted with last=1 and keep=B-(4-n)-1. The input beat is dropped.
  - n <= 4 and no hold (frame <= 4 bytes): one beat is emitted with last=1, abort=1, keep=0, data=0.
- Frame status:
  - abort = CRC mismatch OR length < MIN_FRAME_BYTES (when enabled) OR length > MAX_FRAME_BYTES (when enabled) OR runt.
  - o_fcs_err and o_len_err pulse in the same cycle as the output last beat.
- Input abort (valid=1, abort=1):
  - Held beat is discarded.
  - Next cycle emits one beat: valid=1, last=1, abort=1, keep=0.
  - No error pulse.
  - CRC, length and state reset for the next frame.
- Back-to-back frames:
  - A new frame's first beat may arrive the cycle after last.
  - The tail register drains while the hold register captures the new beat.
  - Output never emits two beats in one cycle and never drops a beat.
- After every last or abort, CRC reinitialises to 0xFFFFFFFF and the length counter to 0.
- Inputs with valid=0 are ignored; idle gaps mid-frame are allowed and produce no output.
- Asynchronous reset mid-frame discards the partial frame. No output after reset until a new frame completes a beat.
- State machine: IDLE (no hold) -> HOLD (beat buffered) -> TAIL (trimmed last beat pending) -> IDLE or HOLD.

Decomposition:
- Shared package eth_pkg holds:
  - CRC32_POLY_REFL = 32'hEDB88320
  - CRC32_INIT = 32'hFFFFFFFF
  - CRC32_RESIDUE = 32'hDEBB20E3
  - ETH_FCS_BYTES = 4
  - function crc32_byte(crc, byte)
- Sub-module eth_crc32_bytes (combinational): CRC state, B bytes and byte count in; next CRC out, computed as a B-deep byte-step chain muxed by count.

Test Plan:
- W=32, MIN=0: beats [31 32 33 34],[35 36 37 38],[39 26 39 F4],[CB] keep=0 -> payload [31..34],[35..38],[39] with last on the third beat, keep=0, abort=0, no error pulses.
- Same frame with byte 0x35 flipped to 0x36 -> identical data; abort=1 on the last beat; o_fcs_err pulses once.
- W=64, 64-byte frame with valid FCS where the last beat has n=8 -> held beat emitted, then trimmed last beat with keep=3; total payload 60 bytes; abort=0.
- Two valid 64-byte frames back-to-back, W=32, no idle -> 30 payload beats; last exactly on beats 15 and 30; no bubbles lost.
- Input abort on beat 3 of a frame -> single beat valid=1, last=1, abort=1; next frame unaffected and passes.
- 3-byte frame (runt) -> single beat last=1, abort=1, keep=0. A 1600-byte valid-CRC frame -> abort=1 and o_len_err pulses. Reset asserted mid-frame -> all outputs 0.
